// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a run-time loadable pattern and overlap select.
// Optional saturating match counter on port match_cnt when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
    parameter int unsigned           PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0]    DEFAULT_PAT = PAT_LEN'(4'b1011),
    parameter int unsigned           CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inp,
    input  logic                 inp_valid,
    input  logic                 overlap,
    input  logic                 pat_load,
    input  logic [PAT_LEN-1:0]   pat_in,
    output logic                 out,
    output logic                 armed
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0]     match_cnt
`endif
);

    localparam int unsigned       FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 32 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: PAT_LEN must be 2..32 and CNT_W at least 1");
    end

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PAT_LEN-1:0]   hist_q, hist_d;
    logic [PAT_LEN-1:0]   pat_q, pat_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 out_d;

    logic [PAT_LEN-1:0]   hist_shift;
    logic [FILL_W-1:0]    fill_inc;
    logic                 match_c;

    // Candidate history and fill level if the current bit is accepted; oldest bit in MSB.
    assign hist_shift = {hist_q[PAT_LEN-2:0], inp};
    assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    assign match_c    = inp_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_shift == pat_q);

    // Next-state and next-output decode; a pattern load discards any bit on the same edge.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        out_d   = 1'b0;

        if (pat_load) begin
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_FILL;
        end else if (inp_valid) begin
            hist_d  = hist_shift;
            fill_d  = fill_inc;
            state_d = (fill_inc == FILL_FULL) ? S_ARMED : S_FILL;
            if (match_c) begin
                out_d = 1'b1;
                if (!overlap) begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = S_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEFAULT_PAT;
            out     <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            out     <= out_d;
            armed   <= (state_d == S_ARMED);
        end
    end

`ifdef SEQDET_COUNT_EN
    // Saturating match count; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (out_d && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: driver queues expected {out, armed} per edge,
// a monitor pops and compares one cycle after each edge.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       inp;
    logic       inp_valid;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       out;
    logic       armed;
`ifdef SEQDET_COUNT_EN
    logic [7:0] match_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_LEN     (4),
        .DEFAULT_PAT (4'b1011),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .inp_valid (inp_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .out       (out),
        .armed     (armed)
`ifdef SEQDET_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    // Apply one edge of stimulus and queue the {out, armed} expected after that edge.
    task automatic drive(input logic r, input logic i, input logic v, input logic ov,
                         input logic ld, input logic [3:0] pin,
                         input logic eo, input logic ea, input string nm);
        @(negedge clk);
        rst       = r;
        inp       = i;
        inp_valid = v;
        overlap   = ov;
        pat_load  = ld;
        pat_in    = pin;
        exp_q.push_back({eo, ea});
        name_q.push_back(nm);
    endtask

    task automatic bit_in(input logic i, input logic ov, input logic eo, input logic ea,
                          input string nm);
        drive(1'b0, i, 1'b1, ov, 1'b0, 4'b0000, eo, ea, nm);
    endtask

    task automatic idle(input logic eo, input logic ea, input string nm);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, eo, ea, nm);
    endtask

    task automatic reset_edge(input string nm);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, nm);
    endtask

    // Monitor: every edge that has a queued expectation is checked 1 time unit later.
    initial begin
        logic [1:0] e;
        string      n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                n_cmp++;
                if ({out, armed} !== e) begin
                    n_err++;
                    $display("FAIL %s: out/armed got %b/%b, expected %b/%b",
                             n, out, armed, e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        inp       = 1'b0;
        inp_valid = 1'b0;
        overlap   = 1'b1;
        pat_load  = 1'b0;
        pat_in    = 4'b0000;

        // 1: overlapping detection of 1011 in 1,0,1,1,0,1,1
        reset_edge("t1_rst0");
        reset_edge("t1_rst1");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t1_b1");
        bit_in(1'b0, 1'b1, 1'b0, 1'b0, "t1_b2");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t1_b3");
        bit_in(1'b1, 1'b1, 1'b1, 1'b1, "t1_b4_match");
        bit_in(1'b0, 1'b1, 1'b0, 1'b1, "t1_b5");
        bit_in(1'b1, 1'b1, 1'b0, 1'b1, "t1_b6");
        bit_in(1'b1, 1'b1, 1'b1, 1'b1, "t1_b7_match");

        // 2: non-overlapping, second occurrence shares bits and must not fire
        reset_edge("t2_rst");
        bit_in(1'b1, 1'b0, 1'b0, 1'b0, "t2_b1");
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "t2_b2");
        bit_in(1'b1, 1'b0, 1'b0, 1'b0, "t2_b3");
        bit_in(1'b1, 1'b0, 1'b1, 1'b0, "t2_b4_match");
        bit_in(1'b0, 1'b0, 1'b0, 1'b0, "t2_b5");
        bit_in(1'b1, 1'b0, 1'b0, 1'b0, "t2_b6");
        bit_in(1'b1, 1'b0, 1'b0, 1'b0, "t2_b7_nomatch");

        // 3: load 1111 with a valid bit on the load edge (discarded), then 8 ones
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, "t3_load");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t3_b1");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t3_b2");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t3_b3");
        for (int k = 4; k <= 8; k++)
            bit_in(1'b1, 1'b1, 1'b1, 1'b1, $sformatf("t3_b%0d_match", k));
        idle(1'b0, 1'b1, "t3_idle");

        // 4: gap of invalid cycles in the middle of the pattern
        reset_edge("t4_rst");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t4_b1");
        bit_in(1'b0, 1'b1, 1'b0, 1'b0, "t4_b2");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t4_b3");
        for (int k = 0; k < 5; k++)
            idle(1'b0, 1'b0, $sformatf("t4_gap%0d", k));
        bit_in(1'b1, 1'b1, 1'b1, 1'b1, "t4_b4_match");
        idle(1'b0, 1'b1, "t4_after");

        // 5: reset mid-stream wipes history; a full fresh pattern is needed
        reset_edge("t5_rst");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t5_b1");
        bit_in(1'b0, 1'b1, 1'b0, 1'b0, "t5_b2");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t5_b3");
        reset_edge("t5_midrst");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t5_after_rst");
        bit_in(1'b0, 1'b1, 1'b0, 1'b0, "t5_c2");
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "t5_c3");
        bit_in(1'b1, 1'b1, 1'b1, 1'b1, "t5_c4_match");
        idle(1'b0, 1'b1, "t5_idle");

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
`ifdef SEQDET_COUNT_EN
        n_cmp++;
        if (match_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL match_cnt: got %0d, expected 1", match_cnt);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
